// File: rtl/del_arb.sv
// Round-robin arbiter and 4-phase handshake sequencer for a shared asynchronous delay unit.
// Optional per-phase timeout with sticky error: define DEL_ARB_TIMEOUT_EN.
module del_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned TMO = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  done,
  output logic          busy,
  output logic          del_req,
  input  logic          del_ack,
  output logic [CW-1:0] lat,
  output logic          err
);

  localparam int unsigned IW = $clog2(N);

`ifdef DEL_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_RISE, S_FALL, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic          ack_m_q, ack_s_q;
  logic [1:0]    warm_q, warm_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          del_req_q, del_req_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] nxt_ptr;
`ifdef DEL_ARB_TIMEOUT_EN
  logic          err_q, err_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
`endif

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    logic [IW:0] j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = {1'b0, ptr_q} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (!pick_vld && req[j[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = j[IW-1:0];
      end
    end
  end

  assign nxt_ptr = (gidx_q == IW'(N-1)) ? '0 : gidx_q + IW'(1);
`ifdef DEL_ARB_TIMEOUT_EN
  assign tmo_hit = (tmo_q == CW'(TMO-1));
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    del_req_d = del_req_q;
    lat_d     = lat_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    warm_d    = warm_q[1] ? warm_q : warm_q + 2'd1;
`ifdef DEL_ARB_TIMEOUT_EN
    err_d     = err_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        // warm_q holds off grants until the synchronizer reflects del_ack after reset
        if (pick_vld && !ack_s_q && warm_q[1]) begin
          state_d   = S_RISE;
          gnt_d     = N'(1) << pick_idx;
          gidx_d    = pick_idx;
          del_req_d = 1'b1;
          cnt_d     = '0;
`ifdef DEL_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
      end
      S_RISE: begin
        if (ack_s_q) begin
          lat_d     = cnt_q;
          del_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_FALL;
`ifdef DEL_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
`ifdef DEL_ARB_TIMEOUT_EN
          if (tmo_hit) begin
            state_d   = S_ERR;
            del_req_d = 1'b0;
            gnt_d     = '0;
            ptr_d     = nxt_ptr;
            err_d     = 1'b1;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
`endif
        end
      end
      S_FALL: begin
        if (!ack_s_q) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = S_DONE;
        end
`ifdef DEL_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_ERR;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
`ifdef DEL_ARB_TIMEOUT_EN
      S_ERR: begin
        if (!ack_s_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ack_m_q   <= 1'b0;
      ack_s_q   <= 1'b0;
      warm_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      del_req_q <= 1'b0;
      lat_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gidx_q    <= '0;
`ifdef DEL_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ack_m_q   <= del_ack;
      ack_s_q   <= ack_m_q;
      warm_q    <= warm_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      del_req_q <= del_req_d;
      lat_q     <= lat_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
`ifdef DEL_ARB_TIMEOUT_EN
      err_q     <= err_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);
  assign del_req = del_req_q;
  assign lat     = lat_q;
`ifdef DEL_ARB_TIMEOUT_EN
  assign err     = err_q;
`else
  // TMO has no effect in this build; the flag is constant low.
  assign err     = 1'b0 & (TMO == 0);
`endif

endmodule
